reg_cmd_seq: RTL and testbench

REG_CMD_SEQ -- requirements
Module: reg_cmd_seq

---
 rtl/reg_cmd_seq_pkg.sv | 15 +
 rtl/reg_cmd_seq_cnt.sv | 28 ++
 rtl/reg_cmd_seq.sv | 151 +++++++++++++++
 tb/tb_reg_cmd_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_cmd_seq_pkg.sv
// Shared encodings for the register command sequencer: command opcodes and FSM states.
package reg_cmd_seq_pkg;

    typedef enum logic {
        OP_LOAD = 1'b0,
        OP_INC  = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        ISSUE = 2'd2
    } state_e;

endpackage

// File: rtl/reg_cmd_seq_cnt.sv
// Loadable down-counter holding the number of INC strobes still to be scheduled.
module reg_cmd_seq_cnt
    import reg_cmd_seq_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/reg_cmd_seq.sv
// Sequencer turning LOAD/INC commands into strobes for a load/increment register,
// inserting a one-cycle SETUP whenever the register's mode select must change.
module reg_cmd_seq
    import reg_cmd_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] reg_in,
    output logic             reg_ld_inc,
    output logic             reg_select,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shadow
);

    state_e             state, state_nx;
    op_e                op_q;
    logic [WIDTH-1:0]   data_q;
    logic               mode;

    logic               accept;
    logic [CNT_W-1:0]   cmd_cnt;
    logic               same_mode;

    logic               ld_inc_nx;
    logic [WIDTH-1:0]   reg_in_nx;
    logic               done_nx;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               cnt_dec;
    logic [CNT_W-1:0]   cnt_count;
    logic               cnt_zero;

    assign cmd_ready  = (state == IDLE);
    assign busy       = !cmd_ready;
    assign accept     = cmd_valid && cmd_ready;
    assign cmd_cnt    = cmd_data[CNT_W-1:0];
    assign same_mode  = (cmd_op == mode);
    assign reg_select = mode;

    reg_cmd_seq_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_count),
        .zero     (cnt_zero)
    );

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = same_mode ? ISSUE : SETUP;
            SETUP:   state_nx = ISSUE;
            ISSUE:   if (!(op_q == OP_INC && reg_ld_inc && !cnt_zero)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Computes the next values of the registered outputs, so each strobe is
    // already on a flop output in the first cycle of the state it belongs to.
    always_comb begin
        ld_inc_nx    = 1'b0;
        reg_in_nx    = reg_in;
        done_nx      = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = cmd_cnt;
        cnt_dec      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    cnt_load = 1'b1;
                    if (same_mode) begin
                        if (op_e'(cmd_op) == OP_LOAD) begin
                            ld_inc_nx = 1'b1;
                            reg_in_nx = cmd_data;
                        end else if (cmd_cnt != '0) begin
                            ld_inc_nx    = 1'b1;
                            cnt_load_val = cmd_cnt - CNT_W'(1);
                        end
                    end
                end
            end
            SETUP: begin
                if (op_q == OP_LOAD) begin
                    ld_inc_nx = 1'b1;
                    reg_in_nx = data_q;
                end else if (!cnt_zero) begin
                    ld_inc_nx = 1'b1;
                    cnt_dec   = 1'b1;
                end
            end
            ISSUE: begin
                if (state_nx == ISSUE) begin
                    ld_inc_nx = 1'b1;
                    cnt_dec   = 1'b1;
                end else begin
                    done_nx = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the latched command is reset too, so no X can reach reg_in after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode       <= 1'b0;
            op_q       <= OP_LOAD;
            data_q     <= '0;
            reg_in     <= '0;
            reg_ld_inc <= 1'b0;
            done       <= 1'b0;
            shadow     <= '0;
        end else begin
            reg_in     <= reg_in_nx;
            reg_ld_inc <= ld_inc_nx;
            done       <= done_nx;
            if (accept) begin
                mode   <= cmd_op;
                op_q   <= op_e'(cmd_op);
                data_q <= cmd_data;
            end
            // Mirrors the downstream register: it acts on the strobe seen this cycle.
            if (reg_ld_inc) begin
                shadow <= reg_select ? shadow + WIDTH'(1) : reg_in;
            end
        end
    end

endmodule

// File: tb/tb_reg_cmd_seq.sv
// Scoreboard bench for reg_cmd_seq: each accepted command queues its expected
// per-cycle output trace; a negedge monitor pops and compares one entry per cycle.
module tb_reg_cmd_seq;
    import reg_cmd_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] reg_in;
    logic       reg_ld_inc;
    logic       reg_select;
    logic       busy;
    logic       done;
    logic [7:0] shadow;

    always #5 clk = ~clk;

    reg_cmd_seq #(
        .WIDTH(8),
        .CNT_W(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .reg_in     (reg_in),
        .reg_ld_inc (reg_ld_inc),
        .reg_select (reg_select),
        .busy       (busy),
        .done       (done),
        .shadow     (shadow)
    );

    typedef struct {
        logic       ld;
        logic       sel;
        logic [7:0] din;
        logic       done;
        logic [7:0] sh;
        logic       busy;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    int         n_vec = 0;
    int         n_bad = 0;
    bit         mon_en = 1'b0;
    logic       m_mode;
    logic [7:0] m_in;
    logic [7:0] m_sh;
    logic [7:0] rm_out;
    logic [7:0] s0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model of the downstream load/increment register.
    always @(posedge clk) begin
        if (rst) rm_out <= 8'h00;
        else if (reg_ld_inc) rm_out <= reg_select ? rm_out + 8'd1 : reg_in;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("reg_model", shadow, rm_out);
            if (q.size() > 0) begin
                cur = q.pop_front();
                check("strobe", reg_ld_inc, cur.ld);
                check("select", reg_select, cur.sel);
                check("reg_in", reg_in, cur.din);
                check("done", done, cur.done);
                check("shadow", shadow, cur.sh);
                check("busy", busy, cur.busy);
            end else begin
                check("idle_strobe", reg_ld_inc, 0);
                check("idle_done", done, 0);
                check("idle_busy", busy, 0);
            end
        end
    end

    // Expected trace of one command, starting in the cycle after its accept edge.
    task automatic push_cmd(input logic op, input logic [7:0] data);
        exp_t e;
        int   n;
        if (op != m_mode) begin
            e = '{1'b0, op, m_in, 1'b0, m_sh, 1'b1};
            q.push_back(e);
        end
        m_mode = op;
        if (op == 1'b0) begin
            e = '{1'b1, 1'b0, data, 1'b0, m_sh, 1'b1};
            q.push_back(e);
            m_in = data;
            m_sh = data;
        end else begin
            n = int'(data[3:0]);
            if (n == 0) begin
                e = '{1'b0, 1'b1, m_in, 1'b0, m_sh, 1'b1};
                q.push_back(e);
            end
            for (int k = 0; k < n; k++) begin
                e = '{1'b1, 1'b1, m_in, 1'b0, m_sh, 1'b1};
                q.push_back(e);
                m_sh = m_sh + 8'd1;
            end
        end
        e = '{1'b0, op, m_in, 1'b1, m_sh, 1'b0};
        q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge with cmd_valid still high.
    task automatic send(input logic op, input logic [7:0] data);
        int waitc = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        while (!cmd_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!cmd_ready) begin
            check("ready_timeout", cmd_ready, 1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            push_cmd(op, data);
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int c = 0;
        cmd_valid = 1'b0;
        while (q.size() != 0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("drain", q.size(), 0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_data  = 8'h00;
        m_mode    = 1'b0;
        m_in      = 8'h00;
        m_sh      = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_reg_in", reg_in, 0);
        check("rst_strobe", reg_ld_inc, 0);
        check("rst_select", reg_select, 0);
        check("rst_done", done, 0);
        check("rst_shadow", shadow, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        send(1'b0, 8'h5A); drain();
        check("load_5a", shadow, 8'h5A);
        send(1'b1, 8'h03); drain();
        check("inc3", shadow, 8'h5D);
        send(1'b0, 8'hFE); drain();
        send(1'b1, 8'h03); drain();
        check("inc_wrap", shadow, 8'h01);
        send(1'b1, 8'h00); drain();
        check("inc0", shadow, 8'h01);
        send(1'b1, 8'hF2); drain();
        check("inc_low_bits", shadow, 8'h03);

        send(1'b0, 8'h33); send(1'b1, 8'h01); drain();
        check("b2b_load_inc", shadow, 8'h34);
        send(1'b1, 8'h02); send(1'b1, 8'h01); drain();
        check("b2b_inc_inc", shadow, 8'h37);

        // Reset during the second strobe of INC 5.
        s0 = m_sh;
        send(1'b1, 8'h05);
        @(posedge clk);
        mon_en = 1'b0;
        q.delete();
        @(negedge clk);
        check("mid_strobe2", reg_ld_inc, 1);
        check("mid_shadow", shadow, s0 + 8'd1);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_reg_in", reg_in, 0);
        check("mid_rst_strobe", reg_ld_inc, 0);
        check("mid_rst_select", reg_select, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_shadow", shadow, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_done", done, 0);
        check("post_rst_strobe", reg_ld_inc, 0);
        check("post_rst_ready", cmd_ready, 1);
        m_mode = 1'b0;
        m_in   = 8'h00;
        m_sh   = 8'h00;
        mon_en = 1'b1;

        send(1'b0, 8'h80); send(1'b1, 8'h00); drain();
        check("post_rst_load", shadow, 8'h80);

        for (int i = 0; i < 12; i++) begin
            send(1'(($urandom_range(0, 1))), 8'($urandom));
        end
        drain();
        check("rand_final", shadow, m_sh);

        @(negedge clk);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
